// File: rtl/mem_access_ctrl.sv
// MEM-stage initiator for the DataMemory request/ready interface.
// Launches one load/store at a time, freezes the pipeline while it is in flight, and registers MEM/WB.
module mem_access_ctrl #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned DEPTH_WORDS = 65536,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_r_en,
  input  logic        req_w_en,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_dest,
  input  logic        req_wb_en,
  output logic        mem_r_en,
  output logic        mem_w_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        freeze,
  output logic        wb_en,
  output logic [3:0]  wb_dest,
  output logic        wb_mem_r_en,
  output logic [31:0] wb_rdata,
  output logic [31:0] wb_alu_res,
  output logic        err_range,
  output logic        err_timeout,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam int unsigned TW = 8;
  localparam int unsigned CW = 16;
  localparam logic [32:0]    ADDR_LO    = 33'(BASE_ADDR);
  localparam logic [32:0]    ADDR_HI    = 33'(BASE_ADDR) + (33'(DEPTH_WORDS) << 2);
  localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0]  CNT_MAX    = '1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, next_state;
  logic [TW-1:0] timer;
  logic          abort_q;
  logic          lat_wb_en;
  logic [3:0]    lat_dest;
  logic          any_req, legal, timer_last;

  assign any_req    = req_r_en | req_w_en;
  assign legal      = (req_r_en ^ req_w_en) && (req_addr[1:0] == 2'b00) &&
                      ({1'b0, req_addr} >= ADDR_LO) && ({1'b0, req_addr} < ADDR_HI);
  assign timer_last = (timer == TIMER_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // After an abort the still-held request is consumed without relaunch, so the pipeline moves on.
  always_comb begin
    next_state = state;
    freeze     = 1'b0;
    case (state)
      IDLE: begin
        if (legal && !abort_q) begin
          next_state = BUSY;
          freeze     = rst;
        end
      end
      BUSY: begin
        freeze = ~mem_ready;
        if (mem_ready || timer_last) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Access latch, MEM/WB register, error flags and completion counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_r_en    <= 1'b0;
      mem_w_en    <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      lat_dest    <= '0;
      lat_wb_en   <= 1'b0;
      timer       <= '0;
      abort_q     <= 1'b0;
      wb_en       <= 1'b0;
      wb_dest     <= '0;
      wb_mem_r_en <= 1'b0;
      wb_rdata    <= '0;
      wb_alu_res  <= '0;
      err_range   <= 1'b0;
      err_timeout <= 1'b0;
      rd_count    <= '0;
      wr_count    <= '0;
    end else begin
      err_range <= 1'b0;
      abort_q   <= 1'b0;
      if (state == IDLE) begin
        if (abort_q) begin
          wb_en <= 1'b0;
        end else if (!any_req) begin
          wb_en       <= req_wb_en;
          wb_dest     <= req_dest;
          wb_alu_res  <= req_addr;
          wb_mem_r_en <= 1'b0;
        end else if (!legal) begin
          err_range <= 1'b1;
          wb_en     <= 1'b0;
        end else begin
          mem_r_en  <= req_r_en;
          mem_w_en  <= req_w_en;
          mem_addr  <= req_addr;
          mem_wdata <= req_wdata;
          lat_dest  <= req_dest;
          lat_wb_en <= req_wb_en;
          timer     <= '0;
          wb_en     <= 1'b0;
        end
      end else if (mem_ready) begin
        if (mem_r_en) begin
          wb_rdata <= mem_rdata;
          if (rd_count != CNT_MAX) rd_count <= rd_count + CW'(1);
        end else begin
          if (wr_count != CNT_MAX) wr_count <= wr_count + CW'(1);
        end
        wb_en       <= lat_wb_en;
        wb_dest     <= lat_dest;
        wb_alu_res  <= mem_addr;
        wb_mem_r_en <= mem_r_en;
        mem_r_en    <= 1'b0;
        mem_w_en    <= 1'b0;
      end else begin
        wb_en <= 1'b0;
        timer <= timer + TW'(1);
        if (timer_last) begin
          err_timeout <= 1'b1;
          abort_q     <= 1'b1;
          mem_r_en    <= 1'b0;
          mem_w_en    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: driver + reference model, memory responder, and MEM/WB monitor.
module tb_mem_access_ctrl;

  localparam int unsigned BASE    = 1024;
  localparam int unsigned DEPTH   = 65536;
  localparam int unsigned TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_r_en, req_w_en, req_wb_en;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_dest;
  logic        mem_r_en, mem_w_en;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;
  logic        freeze, wb_en, wb_mem_r_en, err_range, err_timeout;
  logic [3:0]  wb_dest;
  logic [31:0] wb_rdata, wb_alu_res;
  logic [15:0] rd_count, wr_count;

  mem_access_ctrl #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_r_en(req_r_en), .req_w_en(req_w_en), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_dest(req_dest), .req_wb_en(req_wb_en),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .freeze(freeze), .wb_en(wb_en), .wb_dest(wb_dest), .wb_mem_r_en(wb_mem_r_en),
    .wb_rdata(wb_rdata), .wb_alu_res(wb_alu_res),
    .err_range(err_range), .err_timeout(err_timeout),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          err;
    logic [3:0]  dest;
    bit          mrd;
    logic [31:0] alu;
    logic [31:0] rdata;
  } ev_t;

  typedef struct {
    bit          r;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
  } acc_t;

  ev_t  exp_q[$];
  acc_t acc_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   exp_rd = 0;
  int   exp_wr = 0;
  bit   exp_tout = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_legal(input bit r, input bit w, input logic [31:0] a);
    longint unsigned la;
    la = a;
    return (r != w) && (la % 4 == 0) && (la >= BASE) && (la < BASE + 4 * longint'(DEPTH));
  endfunction

  // Drive one EX/MEM entry, predict its outcome, hold it until the pipeline advances.
  task automatic do_txn(input bit r, input bit w, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] dest, input bit wbe, input int delay, input logic [31:0] rdata);
    ev_t  e;
    acc_t a;
    int   exp_frz, frz;
    bit   f, consumed;
    exp_frz = 0;
    if (!r && !w) begin
      if (wbe) begin
        e = '{err: 1'b0, dest: dest, mrd: 1'b0, alu: addr, rdata: 32'h0};
        exp_q.push_back(e);
      end
    end else if (!is_legal(r, w, addr)) begin
      e = '{err: 1'b1, dest: 4'h0, mrd: 1'b0, alu: 32'h0, rdata: 32'h0};
      exp_q.push_back(e);
    end else begin
      a = '{r: r, addr: addr, wdata: wdata, rdata: rdata, delay: delay};
      acc_q.push_back(a);
      if (delay >= int'(TIMEOUT)) begin
        exp_tout = 1'b1;
        exp_frz  = 1 + int'(TIMEOUT);
      end else begin
        exp_frz = 1 + delay;
        if (r) begin if (exp_rd < 65535) exp_rd++; end
        else   begin if (exp_wr < 65535) exp_wr++; end
        if (wbe) begin
          e = '{err: 1'b0, dest: dest, mrd: r, alu: addr, rdata: rdata};
          exp_q.push_back(e);
        end
      end
    end
    req_r_en = r; req_w_en = w; req_addr = addr; req_wdata = wdata; req_dest = dest; req_wb_en = wbe;
    frz = 0;
    consumed = 1'b0;
    for (int i = 0; i < 1000 && !consumed; i++) begin
      @(negedge clk); #1;
      f = freeze;
      if (f) frz++;
      @(posedge clk);
      if (!f) consumed = 1'b1;
    end
    #1;
    chk("txn_consumed", 32'(consumed), 32'd1);
    chk("freeze_cycles", 32'(frz), 32'(exp_frz));
    chk("rd_count", 32'(rd_count), 32'(exp_rd));
    chk("wr_count", 32'(wr_count), 32'(exp_wr));
  endtask

  // Memory model: answers each access after its scheduled delay and checks the request stays stable.
  initial begin : responder
    bit   active;
    int   cnt;
    acc_t a;
    active = 1'b0;
    cnt = 0;
    a = '{r: 1'b0, addr: 32'h0, wdata: 32'h0, rdata: 32'h0, delay: 0};
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_r_en || mem_w_en) begin
        if (!active) begin
          if (acc_q.size() == 0) begin
            chk("unexpected_access", 32'd1, 32'd0);
            a = '{r: mem_r_en, addr: mem_addr, wdata: mem_wdata, rdata: 32'h0, delay: 0};
          end else begin
            a = acc_q.pop_front();
          end
          active = 1'b1;
          cnt = 0;
        end
        chk("mem_r_en", 32'(mem_r_en), 32'(a.r));
        chk("mem_w_en", 32'(mem_w_en), 32'(!a.r));
        chk("mem_addr", mem_addr, a.addr);
        chk("mem_wdata", mem_wdata, a.wdata);
        mem_ready = (cnt == a.delay);
        mem_rdata = mem_ready ? a.rdata : $urandom;
        cnt++;
      end else begin
        if (active && a.delay < 2000)
          chk("access_cycles", 32'(cnt), (a.delay >= int'(TIMEOUT)) ? 32'(TIMEOUT) : 32'(a.delay + 1));
        active = 1'b0;
        mem_ready = ($urandom_range(0, 7) == 0);
        mem_rdata = $urandom;
      end
    end
  end

  // MEM/WB monitor: every writeback or range-error pulse must match the head of the scoreboard.
  initial begin : monitor
    ev_t e;
    forever begin
      @(negedge clk);
      if (rst && (wb_en || err_range)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", {30'h0, wb_en, err_range}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("out_err_range", 32'(err_range), 32'(e.err));
          chk("out_wb_en", 32'(wb_en), 32'(!e.err));
          if (!e.err) begin
            chk("wb_dest", 32'(wb_dest), 32'(e.dest));
            chk("wb_mem_r_en", 32'(wb_mem_r_en), 32'(e.mrd));
            chk("wb_alu_res", wb_alu_res, e.alu);
            if (e.mrd) chk("wb_rdata", wb_rdata, e.rdata);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk_all_zero(input string nm);
    chk({nm, "_mem_en"}, {30'h0, mem_r_en, mem_w_en}, 32'h0);
    chk({nm, "_freeze"}, 32'(freeze), 32'h0);
    chk({nm, "_wb_en"}, 32'(wb_en), 32'h0);
    chk({nm, "_errs"}, {30'h0, err_range, err_timeout}, 32'h0);
    chk({nm, "_counts"}, {rd_count, wr_count}, 32'h0);
    chk({nm, "_mem_addr"}, mem_addr, 32'h0);
    chk({nm, "_wb_data"}, wb_rdata | wb_alu_res | 32'(wb_dest) | 32'(wb_mem_r_en), 32'h0);
  endtask

  initial begin : driver
    int kind, dly;
    bit r, w, wbe;
    logic [31:0] addr;
    rst = 1'b0;
    req_r_en = 1'b0; req_w_en = 1'b0; req_wb_en = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; req_dest = 4'h0;
    repeat (3) @(negedge clk);
    #2 chk_all_zero("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    do_txn(1, 0, 32'h400, 32'h0, 4'd1, 1, 0, 32'hDEADBEEF);
    do_txn(0, 1, 32'h404, 32'h12345678, 4'd2, 1, 5, 32'h0);
    do_txn(1, 0, 32'h3FC, 32'h0, 4'd3, 1, 0, 32'h0);
    do_txn(1, 0, 32'h402, 32'h0, 4'd3, 1, 0, 32'h0);
    do_txn(1, 1, 32'h408, 32'h0, 4'd3, 1, 0, 32'h0);
    do_txn(1, 0, BASE + 4 * DEPTH - 4, 32'h0, 4'd4, 1, 2, 32'hA5A5_0001);
    do_txn(0, 1, BASE + 4 * DEPTH, 32'h1, 4'd4, 1, 0, 32'h0);
    do_txn(0, 0, 32'hCAFE_0001, 32'h0, 4'd6, 1, 0, 32'h0);
    do_txn(1, 0, 32'h800, 32'h0, 4'd7, 1, int'(TIMEOUT), 32'h0);
    chk("err_timeout_set", 32'(err_timeout), 32'd1);
    chk("abort_enables_low", {30'h0, mem_r_en, mem_w_en}, 32'h0);
    do_txn(1, 0, 32'h804, 32'h0, 4'd8, 1, int'(TIMEOUT) - 1, 32'h1357_9BDF);
    chk("err_timeout_sticky", 32'(err_timeout), 32'd1);
    do_txn(1, 0, 32'h410, 32'h0, 4'd9, 1, 0, 32'h1111_2222);
    do_txn(1, 0, 32'h414, 32'h0, 4'd10, 1, 0, 32'h3333_4444);
    do_txn(0, 0, 32'h0000_BEEF, 32'h0, 4'd11, 1, 0, 32'h0);

    // Reset in the middle of a long access.
    acc_q.push_back('{r: 1'b1, addr: 32'h500, wdata: 32'h55, rdata: 32'h0, delay: 3000});
    req_r_en = 1'b1; req_w_en = 1'b0; req_addr = 32'h500; req_wdata = 32'h55; req_dest = 4'd12; req_wb_en = 1'b1;
    repeat (4) @(negedge clk);
    #1 chk("pre_reset_busy", {30'h0, mem_r_en, freeze}, 32'h3);
    #1 rst = 1'b0;
    #1 chk_all_zero("mid_reset");
    req_r_en = 1'b0; req_wb_en = 1'b0;
    exp_rd = 0; exp_wr = 0; exp_tout = 1'b0;
    @(negedge clk); #2 rst = 1'b1;
    @(posedge clk); #1;
    do_txn(1, 0, 32'h504, 32'h0, 4'd13, 1, 1, 32'h2468_ACE0);

    for (int n = 0; n < 200; n++) begin
      kind = $urandom_range(0, 9);
      wbe  = ($urandom_range(0, 4) != 0);
      dly  = ($urandom_range(0, 24) == 0) ? int'(TIMEOUT) : $urandom_range(0, 6);
      r = 1'b0; w = 1'b0;
      addr = BASE + 4 * $urandom_range(0, DEPTH - 1);
      case (kind)
        0, 1: addr = $urandom;
        2: begin
          r = 1'b1; w = ($urandom_range(0, 1) == 1);
          case ($urandom_range(0, 3))
            0: addr = addr | 32'($urandom_range(1, 3));
            1: addr = BASE - 4 * $urandom_range(1, 8);
            2: addr = BASE + 4 * DEPTH + 4 * $urandom_range(0, 8);
            default: addr = $urandom;
          endcase
        end
        default: if ($urandom_range(0, 1) == 1) r = 1'b1; else w = 1'b1;
      endcase
      do_txn(r, w, addr, $urandom, 4'($urandom), wbe, dly, $urandom);
    end

    do_txn(0, 0, 32'h0, 32'h0, 4'd0, 0, 0, 32'h0);
    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("accesses_empty", 32'(acc_q.size()), 32'd0);
    chk("final_err_timeout", 32'(err_timeout), 32'(exp_tout));
    chk("final_rd_count", 32'(rd_count), 32'(exp_rd));
    chk("final_wr_count", 32'(wr_count), 32'(exp_wr));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
